// File: rtl/fetch_queue_unit.sv
// Instruction fetch: owns the PC, issues word fetches and buffers returned instructions for decode.
// Optional FETCH_BYPASS_EN presents a response arriving at an empty queue combinationally on if_*.
module fetch_queue_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc4,
   output logic [31:0] if_instr
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          inflight_q, inflight_d;
   logic [AW:0]   occ_q, occ_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];

   logic          resp;
   logic          bypass;
   logic          pop;
   logic          q_pop;
   logic          push;
   logic [AW+1:0] credit;

   assign imem_addr = pc_q;

   always_comb begin
      resp = inflight_q & ~redirect_valid;
`ifdef FETCH_BYPASS_EN
      bypass = resp & (occ_q == '0);
`else
      bypass = 1'b0;
`endif
      if_valid = ~redirect_valid & ((occ_q != '0) | bypass);
      if (bypass) begin
         if_pc    = req_pc_q;
         if_instr = imem_rdata;
      end else begin
         if_pc    = pc_mem_q[rd_ptr_q];
         if_instr = instr_mem_q[rd_ptr_q];
      end
      if_pc4 = if_pc + 32'd4;
      pop    = if_valid & if_ready;
      // a bypassed instruction never occupies a slot, so it must not advance the read pointer
      q_pop  = pop & ~bypass;
      push   = resp & ~(bypass & if_ready);
      credit = {1'b0, occ_q} + {{(AW+1){1'b0}}, inflight_q} - {{(AW+1){1'b0}}, pop};
      imem_req = reset & ~redirect_valid & (credit < DEPTH_W);
   end

   always_comb begin
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      inflight_d  = imem_req;
      occ_d       = occ_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;
      if (redirect_valid) begin
         pc_d       = {redirect_pc[31:2], 2'b00};
         inflight_d = 1'b0;
         occ_d      = '0;
         wr_ptr_d   = rd_ptr_q;
      end else begin
         if (imem_req) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
         end
         if (push) begin
            pc_mem_d[wr_ptr_q]    = req_pc_q;
            instr_mem_d[wr_ptr_q] = imem_rdata;
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
         end
         if (q_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         occ_d = occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, q_pop};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         occ_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]    <= '0;
            instr_mem_q[i] <= '0;
         end
      end else begin
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         inflight_q  <= inflight_d;
         occ_q       <= occ_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         pc_mem_q    <= pc_mem_d;
         instr_mem_q <= instr_mem_d;
      end
   end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit (default build, DEPTH=2): per-cycle vector table plus reset sequences.
module tb_fetch_queue_unit;

   localparam int DEPTH = 2;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;
   logic [31:0] if_instr;

   int checks = 0;
   int errors = 0;

   fetch_queue_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .if_valid(if_valid), .if_ready(if_ready),
      .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory: word k holds k; data appears the cycle after a request, junk otherwise
   logic        req_s;
   logic [31:0] addr_s;
   always @(negedge clk) begin
      req_s  <= imem_req;
      addr_s <= imem_addr;
   end
   always @(posedge clk) begin
      imem_rdata <= req_s ? (addr_s >> 2) : 32'hBAD0_BAD0;
   end

   always @(negedge clk) begin
      if (reset && dut.push && dut.occ_q == 2'(DEPTH)) begin
         errors++;
         $display("FAIL overflow: push into full queue at %0t", $time);
      end
   end

   typedef struct {
      logic        ready;
      logic        rv;
      logic [31:0] rpc;
      logic        exp_v;
      logic [31:0] exp_pc;
      logic        exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t tbl [25];
   int   n_vec = 0;

   task automatic add(input logic rdy, input logic rv, input logic [31:0] rpc,
                      input logic v, input logic [31:0] pc, input logic rq, input logic [31:0] a);
      tbl[n_vec].ready    = rdy;
      tbl[n_vec].rv       = rv;
      tbl[n_vec].rpc      = rpc;
      tbl[n_vec].exp_v    = v;
      tbl[n_vec].exp_pc   = pc;
      tbl[n_vec].exp_req  = rq;
      tbl[n_vec].exp_addr = a;
      n_vec++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_head(input string tag, input logic v, input logic [31:0] pc,
                             input logic rq, input logic [31:0] a);
      check({tag, " if_valid"}, {31'b0, if_valid}, {31'b0, v});
      check({tag, " imem_req"}, {31'b0, imem_req}, {31'b0, rq});
      check({tag, " imem_addr"}, imem_addr, a);
      if (v) begin
         check({tag, " if_pc"}, if_pc, pc);
         check({tag, " if_pc4"}, if_pc4, pc + 32'd4);
         check({tag, " if_instr"}, if_instr, pc >> 2);
      end
   endtask

   initial begin
      reset          = 1'b0;
      if_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;

      // stall from reset, release, redirects to 0x100, 0x203, 0xFFFF_FFFC
      add(0, 0, 0,            0, 0,            1, 32'h0);
      add(0, 0, 0,            0, 0,            1, 32'h4);
      add(0, 0, 0,            1, 32'h0,        0, 32'h8);
      add(0, 0, 0,            1, 32'h0,        0, 32'h8);
      add(0, 0, 0,            1, 32'h0,        0, 32'h8);
      add(0, 0, 0,            1, 32'h0,        0, 32'h8);
      add(1, 0, 0,            1, 32'h0,        1, 32'h8);
      add(1, 0, 0,            1, 32'h4,        1, 32'hC);
      add(1, 0, 0,            1, 32'h8,        1, 32'h10);
      add(1, 0, 0,            1, 32'hC,        1, 32'h14);
      add(1, 1, 32'h100,      0, 0,            0, 32'h18);
      add(1, 0, 0,            0, 0,            1, 32'h100);
      add(1, 0, 0,            0, 0,            1, 32'h104);
      add(1, 0, 0,            1, 32'h100,      1, 32'h108);
      add(1, 0, 0,            1, 32'h104,      1, 32'h10C);
      add(1, 1, 32'h203,      0, 0,            0, 32'h110);
      add(1, 0, 0,            0, 0,            1, 32'h200);
      add(1, 0, 0,            0, 0,            1, 32'h204);
      add(1, 0, 0,            1, 32'h200,      1, 32'h208);
      add(1, 1, 32'hFFFF_FFFC, 0, 0,           0, 32'h20C);
      add(1, 0, 0,            0, 0,            1, 32'hFFFF_FFFC);
      add(1, 0, 0,            0, 0,            1, 32'h0);
      add(1, 0, 0,            1, 32'hFFFF_FFFC, 1, 32'h4);
      add(1, 0, 0,            1, 32'h0,        1, 32'h8);
      add(1, 0, 0,            1, 32'h4,        1, 32'hC);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst imem_req", {31'b0, imem_req}, 32'h0);
      check("rst imem_addr", imem_addr, 32'h0);
      check("rst if_valid", {31'b0, if_valid}, 32'h0);
      check("rst if_pc", if_pc, 32'h0);
      check("rst if_pc4", if_pc4, 32'h4);
      check("rst if_instr", if_instr, 32'h0);

      for (int i = 0; i < n_vec; i++) begin
         @(posedge clk);
         #1;
         reset          = 1'b1;
         if_ready       = tbl[i].ready;
         redirect_valid = tbl[i].rv;
         redirect_pc    = tbl[i].rpc;
         @(negedge clk);
         check_head($sformatf("vec%0d", i), tbl[i].exp_v, tbl[i].exp_pc,
                    tbl[i].exp_req, tbl[i].exp_addr);
      end

      // asynchronous reset pulse mid-cycle with a fetch outstanding
      #2 reset = 1'b0;
      #1;
      check("midrst if_valid", {31'b0, if_valid}, 32'h0);
      check("midrst imem_req", {31'b0, imem_req}, 32'h0);
      check("midrst imem_addr", imem_addr, 32'h0);
      check("midrst if_pc", if_pc, 32'h0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      check_head("restart0", 1'b0, 32'h0, 1'b1, 32'h0);
      @(negedge clk);
      check_head("restart1", 1'b0, 32'h0, 1'b1, 32'h4);
      @(negedge clk);
      check_head("restart2", 1'b1, 32'h0, 1'b1, 32'h8);
      @(negedge clk);
      check_head("restart3", 1'b1, 32'h4, 1'b1, 32'hC);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
